regfile_writeback: RTL
======================

Name: regfile_writeback

Overview:
- Write side of the 8 x 16-bit datapath register bank; the counterpart of the read port that selects a register by readnum into the A/B operand registers.
- Owns the C result register, the Z status flag, the writeback source mux (vsel) and the register storage itself.
- Runs a two-state request/commit handshake with the controller and exports all eight registers flat to the read side.

Parameters:
- WIDTH, 16, datapath and register width in bits.
- PCW, 8, program-counter width; zero-extended to WIDTH when selected.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- loadc  in  1  capture alu_out into C at the clock edge.
- loads  in  1  capture alu_z into Z at the clock edge.
- alu_out  in  WIDTH  ALU result.
- alu_z  in  1  ALU zero flag.
- vsel  in  2  writeback source select.
- mdata  in  WIDTH  memory read data.
- sximm8  in  WIDTH  sign-extended immediate.
- pc  in  PCW  program counter.
- wb_req  in  1  writeback request, level, sampled only in IDLE.
- writenum  in  3  destination register index.
- wb_busy  out  1  high while in COMMIT (combinational from state).
- wb_ack  out  1  registered one-cycle pulse when the write lands.
- C  out  WIDTH  result register.
- Z  out  1  status register.
- regs_flat  out  8*WIDTH  R7..R0 concatenated; R0 in bits [WIDTH-1:0].

Behaviour:
- Reset (rst_n low, asynchronous):
  - R0..R7, C and Z clear to 0.
  - state goes to IDLE; wb_ack = 0, wb_busy = 0.
  - A pending write is discarded and never lands.
- C/Z:
  - On each edge, C <= alu_out if loadc; Z <= alu_z if loads.
  - These loads are independent of the FSM and act in any state.
- Source mux, evaluated from pre-edge values:
  - vsel 00: C.
  - vsel 01: {zeros, pc}.
  - vsel 10: sximm8.
  - vsel 11: mdata.
- FSM states: IDLE, COMMIT.
  - IDLE with wb_req=1 at an edge:
    - data_lat <= mux output; num_lat <= writenum.
    - state <= COMMIT.
  - COMMIT, next edge:
    - R[num_lat] <= data_lat; wb_ack <= 1.
    - state <= IDLE.
  - wb_ack is high for exactly the one cycle after the commit edge and 0 otherwise.
- Latency: request sampled at edge N; register updated and visible on regs_flat after edge N+1; wb_ack high during cycle N+1..N+2.
- Request timing:
  - wb_req while in COMMIT is ignored, neither queued nor latched.
  - A requester holding wb_req high gets back-to-back writes every 2 cycles.
  - wb_req sampled in the ack cycle (state IDLE) starts a new write immediately.
- Simultaneous events:
  - loadc=1 and a wb_req capture with vsel=00 in the same edge: the capture takes the OLD C.
  - A commit to register k while the read side reads k in the same cycle: the read sees the old value until after the commit edge.
- Sources sampled only at the capture edge; changes on mdata/pc/sximm8/C during COMMIT have no effect on the written value.
- All 3-bit writenum values are valid; no default/X case.

Optional Feature:
- Macro WB_R0_ZERO_EN.
- Defined:
  - R0 is hardwired to 0 and commits to index 0 are dropped.
  - wb_ack still pulses for a dropped commit.
  - regs_flat[WIDTH-1:0] is constant 0.
- Undefined: R0 is an ordinary writable register.

Test Plan:
- Reset mid-write: wb_req, vsel=10, sximm8=16'h00FF, writenum=3; assert rst_n low in COMMIT -> R3 stays 0, wb_ack 0, state IDLE after release.
- Basic write: wb_req 1 cycle, vsel=11, mdata=16'hBEEF, writenum=5 -> after 2 edges R5=16'hBEEF, wb_ack single 1-cycle pulse, wb_busy high exactly 1 cycle.
- C old-value capture: C=16'h0001, alu_out=16'h0002, loadc=1 and wb_req with vsel=00, writenum=2 on the same edge -> R2=16'h0001 and C=16'h0002.
- PC zero-extension and held request: pc=8'hA5, vsel=01, wb_req held high for 4 cycles, writenum=7 -> R7=16'h00A5, exactly 2 wb_ack pulses, wb_req during COMMIT ignored.
- Z flag: loads=1, alu_z=1 while idle -> Z=1; loads=0, alu_z=0 next cycle -> Z stays 1.
- R0 write: vsel=10, sximm8=16'hFFF0, writenum=0 -> R0=16'hFFF0 without WB_R0_ZERO_EN; R0=0 with it, wb_ack pulses in both builds.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Writeback request/ack bus between the controller (master) and the register bank write side (slave).
interface regfile_writeback_if #(
    parameter int WIDTH = 16,
    parameter int PCW   = 8
);
    logic             wb_req;
    logic [2:0]       writenum;
    logic [1:0]       vsel;
    logic [WIDTH-1:0] mdata;
    logic [WIDTH-1:0] sximm8;
    logic [PCW-1:0]   pc;
    logic             wb_busy;
    logic             wb_ack;

    modport master (
        output wb_req, writenum, vsel, mdata, sximm8, pc,
        input  wb_busy, wb_ack
    );

    modport slave (
        input  wb_req, writenum, vsel, mdata, sximm8, pc,
        output wb_busy, wb_ack
    );
endinterface

// File: rtl/regfile_writeback.sv
// Write side of the 8-entry register bank: C/Z registers, writeback source mux, IDLE/COMMIT handshake.
// Optional macro WB_R0_ZERO_EN hardwires R0 to zero and drops commits to index 0.
module regfile_writeback #(
    parameter int WIDTH = 16,
    parameter int PCW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_writeback_if.slave   wb,
    input  logic                 loadc,
    input  logic                 loads,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_z,
    output logic [WIDTH-1:0]     C,
    output logic                 Z,
    output logic [8*WIDTH-1:0]   regs_flat
);

`ifdef WB_R0_ZERO_EN
    localparam int REG_LO = 1;
`else
    localparam int REG_LO = 0;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t           state;
    logic             ack_q;
    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] data_lat;
    logic [2:0]       num_lat;
    logic [WIDTH-1:0] regs [REG_LO:7];

    // Source mux sees pre-edge C, so a same-edge loadc never leaks into the capture.
    always_comb begin
        src_data = C;
        case (wb.vsel)
            2'b00: src_data = C;
            2'b01: src_data = {{(WIDTH-PCW){1'b0}}, wb.pc};
            2'b10: src_data = wb.sximm8;
            2'b11: src_data = wb.mdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C <= '0;
            Z <= 1'b0;
        end else begin
            if (loadc) C <= alu_out;
            if (loads) Z <= alu_z;
        end
    end

    // Requests arriving during COMMIT are simply not looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ack_q    <= 1'b0;
            data_lat <= '0;
            num_lat  <= '0;
            for (int i = REG_LO; i < 8; i++) regs[i] <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb.wb_req) begin
                        data_lat <= src_data;
                        num_lat  <= wb.writenum;
                        state    <= COMMIT;
                    end
                end
                COMMIT: begin
`ifdef WB_R0_ZERO_EN
                    if (num_lat != 3'd0) regs[num_lat] <= data_lat;
`else
                    regs[num_lat] <= data_lat;
`endif
                    ack_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wb.wb_busy = (state == COMMIT);
    assign wb.wb_ack  = ack_q;

    for (genvar g = 0; g < 8; g++) begin : g_flat
        if (g < REG_LO) begin : g_zero
            assign regs_flat[g*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
        end
    end

endmodule
